// File: rtl/cdb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdb_pkg                                                      |
// | Description : Shared types and default widths for the CDB transmit side.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cdb_pkg;

    localparam int c_WIDTH = 31;
    localparam int c_ROB   = 2;
    localparam int c_DEPTH = 2;

    typedef enum logic [0:0] {
        SRC_ALU    = 1'b0,
        SRC_BRANCH = 1'b1
    } cdb_src_t;

    typedef struct packed {
        logic [c_ROB:0]   rob;
        logic [c_WIDTH:0] result;
        logic             isBranch;
        logic [c_WIDTH:0] target;
        logic             mispredict;
    } cdb_entry_t;

    function automatic cdb_src_t otherSrc(input cdb_src_t s);
        return (s == SRC_ALU) ? SRC_BRANCH : SRC_ALU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdb_if                                                       |
// | Description : Producer handshakes and CDB broadcast bundle.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface cdb_if
    import cdb_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int ROB   = c_ROB
);

    logic             aluValid;
    logic [ROB:0]     aluRob;
    logic [WIDTH:0]   aluResult;
    logic             aluReady;

    logic             brValid;
    logic [ROB:0]     brRob;
    logic [WIDTH:0]   brResult;
    logic [WIDTH:0]   brTarget;
    logic             brMispredict;
    logic             brReady;

    logic             cdbValid;
    logic [ROB:0]     cdbRob;
    logic [WIDTH:0]   cdbResult;
    logic             cdbIsBranch;
    logic [WIDTH:0]   cdbTarget;
    logic             cdbMispredict;

    modport master (
        output aluValid, aluRob, aluResult,
        output brValid, brRob, brResult, brTarget, brMispredict,
        input  aluReady, brReady,
        input  cdbValid, cdbRob, cdbResult, cdbIsBranch, cdbTarget, cdbMispredict
    );

    modport slave (
        input  aluValid, aluRob, aluResult,
        input  brValid, brRob, brResult, brTarget, brMispredict,
        output aluReady, brReady,
        output cdbValid, cdbRob, cdbResult, cdbIsBranch, cdbTarget, cdbMispredict
    );

endinterface
`default_nettype wire

// File: rtl/cdb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdb_fifo                                                     |
// | Description : Small per-source result FIFO with synchronous flush.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cdb_fifo
    import cdb_pkg::*;
#(
    parameter int  DEPTH = c_DEPTH,
    parameter type T     = cdb_entry_t
) (
    input  wire logic clk,
    input  wire logic globalReset,
    input  wire logic clear,
    input  wire logic pushValid,
    input  wire T     pushData,
    output logic      pushReady,
    input  wire logic popEn,
    output T          popData,
    output logic      empty
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_PW = c_AW + 1;

    T                r_mem [DEPTH];
    logic [c_PW-1:0] r_wrPtr;
    logic [c_PW-1:0] r_rdPtr;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    // Extra pointer MSB tells a full buffer apart from an empty one.
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[c_PW-1] != r_rdPtr[c_PW-1]) &&
                     (r_wrPtr[c_AW-1:0] == r_rdPtr[c_AW-1:0]);

    assign w_push    = pushValid && !w_full && !clear;
    assign w_pop     = popEn && !w_empty && !clear;
    assign pushReady = !w_full;
    assign empty     = w_empty;
    assign popData   = r_mem[r_rdPtr[c_AW-1:0]];

    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + c_PW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + c_PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr[c_AW-1:0]] <= pushData;
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdb_arbiter                                                  |
// | Description : Round-robin ALU/branch arbiter driving a registered CDB.     |
// |               Define CDB_BYPASS_EN to let an empty, granted source skip    |
// |               its FIFO (1-cycle latency).                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int ROB   = c_ROB,
    parameter int DEPTH = c_DEPTH
) (
    input  wire logic clk,
    input  wire logic globalReset,
    input  wire logic clear,
    cdb_if.slave      bus
);

    typedef struct packed {
        logic [ROB:0]   rob;
        logic [WIDTH:0] result;
        logic           isBranch;
        logic [WIDTH:0] target;
        logic           mispredict;
    } entry_t;

    entry_t   w_aluIn;
    entry_t   w_brIn;
    entry_t   w_aluHead;
    entry_t   w_brHead;
    entry_t   w_next;
    logic     w_aluEmpty;
    logic     w_brEmpty;
    logic     w_aluReq;
    logic     w_brReq;
    logic     w_grantAlu;
    logic     w_grantBr;
    logic     w_aluBypass;
    logic     w_brBypass;
    logic     w_aluPush;
    logic     w_brPush;

    entry_t   r_cdb;
    logic     r_cdbValid;
    cdb_src_t r_rrPtr;

    always_comb begin
        w_aluIn        = '0;
        w_aluIn.rob    = bus.aluRob;
        w_aluIn.result = bus.aluResult;

        w_brIn            = '0;
        w_brIn.rob        = bus.brRob;
        w_brIn.result     = bus.brResult;
        w_brIn.isBranch   = 1'b1;
        w_brIn.target     = bus.brTarget;
        w_brIn.mispredict = bus.brMispredict;
    end

`ifdef CDB_BYPASS_EN
    // An empty FIFO is never full, so a valid input there is always acceptable.
    assign w_aluReq    = !w_aluEmpty || bus.aluValid;
    assign w_brReq     = !w_brEmpty  || bus.brValid;
    assign w_aluBypass = w_grantAlu && w_aluEmpty;
    assign w_brBypass  = w_grantBr  && w_brEmpty;
`else
    assign w_aluReq    = !w_aluEmpty;
    assign w_brReq     = !w_brEmpty;
    assign w_aluBypass = 1'b0;
    assign w_brBypass  = 1'b0;
`endif

    assign w_grantAlu = w_aluReq && (!w_brReq || (r_rrPtr == SRC_ALU));
    assign w_grantBr  = w_brReq  && !w_grantAlu;

    assign w_aluPush = bus.aluValid && !w_aluBypass;
    assign w_brPush  = bus.brValid  && !w_brBypass;

    always_comb begin
        w_next = w_brEmpty ? w_brIn : w_brHead;
        if (w_grantAlu) w_next = w_aluEmpty ? w_aluIn : w_aluHead;
    end

    cdb_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_aluFifo (
        .clk         (clk),
        .globalReset (globalReset),
        .clear       (clear),
        .pushValid   (w_aluPush),
        .pushData    (w_aluIn),
        .pushReady   (bus.aluReady),
        .popEn       (w_grantAlu),
        .popData     (w_aluHead),
        .empty       (w_aluEmpty)
    );

    cdb_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_brFifo (
        .clk         (clk),
        .globalReset (globalReset),
        .clear       (clear),
        .pushValid   (w_brPush),
        .pushData    (w_brIn),
        .pushReady   (bus.brReady),
        .popEn       (w_grantBr),
        .popData     (w_brHead),
        .empty       (w_brEmpty)
    );

    // Fields other than valid hold when idle; consumers qualify on cdbValid.
    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            r_cdbValid <= 1'b0;
            r_cdb      <= '0;
            r_rrPtr    <= SRC_ALU;
        end else if (clear) begin
            r_cdbValid <= 1'b0;
            r_rrPtr    <= SRC_ALU;
        end else begin
            r_cdbValid <= w_grantAlu || w_grantBr;
            if (w_grantAlu || w_grantBr) r_cdb <= w_next;
            if (w_aluReq && w_brReq)     r_rrPtr <= otherSrc(r_rrPtr);
        end
    end

    assign bus.cdbValid      = r_cdbValid;
    assign bus.cdbRob        = r_cdb.rob;
    assign bus.cdbResult     = r_cdb.result;
    assign bus.cdbIsBranch   = r_cdb.isBranch;
    assign bus.cdbTarget     = r_cdb.target;
    assign bus.cdbMispredict = r_cdb.mispredict;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cdb_arbiter                                               |
// | Description : Vector table plus queue-model scoreboard for cdb_arbiter.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cdb_arbiter;

    localparam int WIDTH = 31;
    localparam int ROB   = 2;
    localparam int DEPTH = 2;
`ifdef CDB_BYPASS_EN
    localparam int c_SHIFT = 1;
    localparam int c_LAT   = 1;
`else
    localparam int c_SHIFT = 0;
    localparam int c_LAT   = 2;
`endif

    typedef struct packed {
        logic [2:0]  rob;
        logic [31:0] res;
        logic        isBr;
        logic [31:0] tgt;
        logic        mis;
    } ent_t;

    typedef struct {
        logic        av;
        logic [2:0]  ar;
        logic [31:0] ares;
        logic        bv;
        logic [2:0]  br;
        logic [31:0] bres;
        logic [31:0] btgt;
        logic        bmis;
        logic        ev;
        ent_t        e;
    } vec_t;

    logic clk         = 1'b0;
    logic globalReset = 1'b0;
    logic clear       = 1'b0;

    cdb_if #(.WIDTH(WIDTH), .ROB(ROB)) bus ();

    cdb_arbiter #(.WIDTH(WIDTH), .ROB(ROB), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .globalReset (globalReset),
        .clear       (clear),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];

    ent_t mAlu[$];
    ent_t mBr[$];
    ent_t sbQ[$];
    logic mRr    = 1'b0;
    logic mValid = 1'b0;
    ent_t mAE, mBE, mE, mOut;
    int   mASz, mBSz;
    logic mAIn, mBIn, mAReq, mBReq, mGA, mGB;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] ar, input logic [31:0] ares,
                         input logic bv, input logic [2:0] br, input logic [31:0] bres,
                         input logic [31:0] btgt, input logic bmis);
        bus.aluValid     = av;
        bus.aluRob       = ar;
        bus.aluResult    = ares;
        bus.brValid      = bv;
        bus.brRob        = br;
        bus.brResult     = bres;
        bus.brTarget     = btgt;
        bus.brMispredict = bmis;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic addRow(input logic av, input logic [2:0] ar, input logic [31:0] ares,
                          input logic bv, input logic [2:0] br, input logic [31:0] bres,
                          input logic [31:0] btgt, input logic bmis,
                          input logic ev, input logic [2:0] erob, input logic [31:0] eres,
                          input logic eisBr, input logic [31:0] etgt, input logic emis);
        vec_t v;
        v.av = av; v.ar = ar; v.ares = ares;
        v.bv = bv; v.br = br; v.bres = bres; v.btgt = btgt; v.bmis = bmis;
        v.ev = ev;
        v.e  = '{rob: erob, res: eres, isBr: eisBr, tgt: etgt, mis: emis};
        tbl.push_back(v);
    endtask

    // Reference model: two queues and a round-robin bit, stepped at each edge.
    initial forever begin
        @(posedge clk or negedge globalReset);
        if (!globalReset) begin
            mAlu.delete(); mBr.delete(); sbQ.delete();
            mRr = 1'b0; mValid = 1'b0;
        end else if (clear) begin
            mAlu.delete(); mBr.delete();
            mRr = 1'b0; mValid = 1'b0;
        end else begin
            mAE  = '{rob: bus.aluRob, res: bus.aluResult, isBr: 1'b0, tgt: 32'h0, mis: 1'b0};
            mBE  = '{rob: bus.brRob, res: bus.brResult, isBr: 1'b1, tgt: bus.brTarget, mis: bus.brMispredict};
            mASz = mAlu.size();
            mBSz = mBr.size();
            mAIn = bus.aluValid && (mASz < DEPTH);
            mBIn = bus.brValid  && (mBSz < DEPTH);
            mAReq = (mASz > 0);
            mBReq = (mBSz > 0);
`ifdef CDB_BYPASS_EN
            mAReq = mAReq || mAIn;
            mBReq = mBReq || mBIn;
`endif
            mGA = mAReq && (!mBReq || !mRr);
            mGB = mBReq && !mGA;
            mValid = mGA || mGB;
            mOut = '0;
            if (mGA) begin
                if (mASz > 0) mOut = mAlu.pop_front();
                else begin mOut = mAE; mAIn = 1'b0; end
            end else if (mGB) begin
                if (mBSz > 0) mOut = mBr.pop_front();
                else begin mOut = mBE; mBIn = 1'b0; end
            end
            if (mValid) sbQ.push_back(mOut);
            if (mAReq && mBReq) mRr = !mRr;
            if (mAIn) mAlu.push_back(mAE);
            if (mBIn) mBr.push_back(mBE);
        end
    end

    // Scoreboard: compare DUT against the model away from the active edge.
    initial forever begin
        @(negedge clk);
        if (globalReset === 1'b1) begin
            chk("sb_alu_ready", 64'(bus.aluReady), 64'(mAlu.size() < DEPTH));
            chk("sb_br_ready",  64'(bus.brReady),  64'(mBr.size() < DEPTH));
            chk("sb_valid",     64'(bus.cdbValid), 64'(mValid));
            if (sbQ.size() > 0) begin
                mE = sbQ.pop_front();
                if (bus.cdbValid) begin
                    chk("sb_rob",    64'(bus.cdbRob),        64'(mE.rob));
                    chk("sb_result", 64'(bus.cdbResult),     64'(mE.res));
                    chk("sb_isbr",   64'(bus.cdbIsBranch),   64'(mE.isBr));
                    chk("sb_target", 64'(bus.cdbTarget),     64'(mE.tgt));
                    chk("sb_mispr",  64'(bus.cdbMispredict), 64'(mE.mis));
                end
            end
        end
    end

    initial begin
        int   aCnt, bCnt, fullA, fullB, altBad, nBc, n;
        logic accA, accB, prevBr, havePrev, seen;

        idle();
        repeat (2) @(negedge clk);
        chk("reset_valid",  64'(bus.cdbValid),      64'(0));
        chk("reset_rob",    64'(bus.cdbRob),        64'(0));
        chk("reset_result", 64'(bus.cdbResult),     64'(0));
        chk("reset_isbr",   64'(bus.cdbIsBranch),   64'(0));
        chk("reset_target", 64'(bus.cdbTarget),     64'(0));
        chk("reset_mispr",  64'(bus.cdbMispredict), 64'(0));
        globalReset = 1'b1;
        @(negedge clk);
        chk("reset_alu_ready", 64'(bus.aluReady), 64'(1));
        chk("reset_br_ready",  64'(bus.brReady),  64'(1));

        // Expected columns give what is visible once the row has been clocked (FIFO path).
        addRow(1'b1, 3'd3, 32'h10, 1'b0, 3'd0, 32'h0,  32'h0,  1'b0,  1'b0, 3'd0, 32'h0,  1'b0, 32'h0,  1'b0);
        addRow(1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  32'h0,  1'b0,  1'b1, 3'd3, 32'h10, 1'b0, 32'h0,  1'b0);
        addRow(1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  32'h0,  1'b0,  1'b0, 3'd0, 32'h0,  1'b0, 32'h0,  1'b0);
        addRow(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22, 32'h30, 1'b0,  1'b0, 3'd0, 32'h0,  1'b0, 32'h0,  1'b0);
        addRow(1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  32'h0,  1'b0,  1'b1, 3'd1, 32'h11, 1'b0, 32'h0,  1'b0);
        addRow(1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  32'h0,  1'b0,  1'b1, 3'd2, 32'h22, 1'b1, 32'h30, 1'b0);
        addRow(1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  32'h0,  1'b0,  1'b0, 3'd0, 32'h0,  1'b0, 32'h0,  1'b0);
        addRow(1'b1, 3'd4, 32'h44, 1'b1, 3'd5, 32'h55, 32'h50, 1'b1,  1'b0, 3'd0, 32'h0,  1'b0, 32'h0,  1'b0);
        addRow(1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  32'h0,  1'b0,  1'b1, 3'd5, 32'h55, 1'b1, 32'h50, 1'b1);
        addRow(1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  32'h0,  1'b0,  1'b1, 3'd4, 32'h44, 1'b0, 32'h0,  1'b0);
        addRow(1'b0, 3'd0, 32'h0,  1'b1, 3'd6, 32'h24, 32'h40, 1'b1,  1'b0, 3'd0, 32'h0,  1'b0, 32'h0,  1'b0);
        addRow(1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  32'h0,  1'b0,  1'b1, 3'd6, 32'h24, 1'b1, 32'h40, 1'b1);
        addRow(1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  32'h0,  1'b0,  1'b0, 3'd0, 32'h0,  1'b0, 32'h0,  1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].av, tbl[i].ar, tbl[i].ares, tbl[i].bv, tbl[i].br,
                  tbl[i].bres, tbl[i].btgt, tbl[i].bmis);
            @(negedge clk);
            if (i + c_SHIFT < tbl.size()) begin
                chk($sformatf("vec%0d_valid", i), 64'(bus.cdbValid), 64'(tbl[i+c_SHIFT].ev));
                if (tbl[i+c_SHIFT].ev) begin
                    chk($sformatf("vec%0d_rob", i),    64'(bus.cdbRob),        64'(tbl[i+c_SHIFT].e.rob));
                    chk($sformatf("vec%0d_result", i), 64'(bus.cdbResult),     64'(tbl[i+c_SHIFT].e.res));
                    chk($sformatf("vec%0d_isbr", i),   64'(bus.cdbIsBranch),   64'(tbl[i+c_SHIFT].e.isBr));
                    chk($sformatf("vec%0d_target", i), 64'(bus.cdbTarget),     64'(tbl[i+c_SHIFT].e.tgt));
                    chk($sformatf("vec%0d_mispr", i),  64'(bus.cdbMispredict), 64'(tbl[i+c_SHIFT].e.mis));
                end
            end
        end
        idle();
        repeat (2) @(negedge clk);

        // Back-pressure: both sources always valid, holding data while not ready.
        aCnt = 0; bCnt = 0; fullA = 0; fullB = 0; altBad = 0; nBc = 0;
        prevBr = 1'b0; havePrev = 1'b0;
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, aCnt[2:0], 32'hA000_0000 + aCnt,
                  1'b1, bCnt[2:0], 32'hB000_0000 + bCnt, bCnt * 4, bCnt[0]);
            accA = bus.aluReady;
            accB = bus.brReady;
            if (!accA) fullA++;
            if (!accB) fullB++;
            @(negedge clk);
            if (accA) aCnt++;
            if (accB) bCnt++;
            if (bus.cdbValid) begin
                nBc++;
                if (havePrev && (bus.cdbIsBranch == prevBr)) altBad++;
                prevBr   = bus.cdbIsBranch;
                havePrev = 1'b1;
            end
        end
        idle();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.cdbValid) nBc++;
        end
        chk("bp_alu_full_seen", 64'(fullA > 0), 64'(1));
        chk("bp_br_full_seen",  64'(fullB > 0), 64'(1));
        chk("bp_alternate",     64'(altBad),    64'(0));
        chk("bp_count",         64'(nBc),       64'(aCnt + bCnt));

        // Clear with entries buffered and a new ALU input on the same edge.
        drive(1'b1, 3'd1, 32'hC1, 1'b1, 3'd2, 32'hC2, 32'h80, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'd3, 32'hC3, 1'b1, 3'd4, 32'hC4, 32'h84, 1'b1);
        @(negedge clk);
        drive(1'b1, 3'd5, 32'hC5, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        idle();
        chk("clear_valid",     64'(bus.cdbValid), 64'(0));
        chk("clear_alu_ready", 64'(bus.aluReady), 64'(1));
        chk("clear_br_ready",  64'(bus.brReady),  64'(1));
        nBc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.cdbValid) nBc++;
        end
        chk("clear_no_bcast", 64'(nBc), 64'(0));

        // Asynchronous reset while a broadcast is on the bus.
        drive(1'b1, 3'd2, 32'hD1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        idle();
        seen = bus.cdbValid;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            seen = bus.cdbValid;
        end
        chk("rst_pre_valid", 64'(seen), 64'(1));
        #2 globalReset = 1'b0;
        #1;
        chk("rst_async_valid",  64'(bus.cdbValid),  64'(0));
        chk("rst_async_rob",    64'(bus.cdbRob),    64'(0));
        chk("rst_async_result", 64'(bus.cdbResult), 64'(0));
        @(negedge clk);
        globalReset = 1'b1;
        drive(1'b1, 3'd7, 32'h77, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            idle();
            n++;
            seen = bus.cdbValid;
        end
        chk("rst_latency",    64'(n),             64'(c_LAT));
        chk("rst_first_rob",  64'(bus.cdbRob),    64'(7));
        chk("rst_first_data", 64'(bus.cdbResult), 64'(32'h77));
        @(negedge clk);
        chk("rst_one_cycle",  64'(bus.cdbValid),  64'(0));

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Transmit side of the common data bus (CDB).
- Accepts completed results from the ALU and branch functional units over valid/ready handshakes and buffers each source in a small FIFO.
- Round-robin arbitration picks one result; it is broadcast per cycle from a registered CDB output to reservation stations, rename bypass and the reorder buffer.
- A control-flow clear from the ROB flushes all buffered results.

Parameters:
- WIDTH, 31: MSB index of data/PC fields (32-bit values).
- ROB, 2: MSB index of the ROB tag (8 entries).
- DEPTH, 2: entries per source FIFO; must be a power of 2, at least 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- globalReset  input  1  asynchronous, active-low reset (0 = reset).
- clear  input  1  synchronous flush from ROB control-flow commit.
- aluValid  input  1  ALU result present.
- aluRob  input  ROB+1  ROB tag of ALU result.
- aluResult  input  WIDTH+1  ALU result value.
- aluReady  output  1  ALU FIFO can accept.
- brValid  input  1  branch result present.
- brRob  input  ROB+1  ROB tag of branch result.
- brResult  input  WIDTH+1  link value (PC+4) or 0.
- brTarget  input  WIDTH+1  resolved next PC.
- brMispredict  input  1  prediction was wrong.
- brReady  output  1  branch FIFO can accept.
- cdbValid  output  1  broadcast valid this cycle.
- cdbRob  output  ROB+1  tag being broadcast.
- cdbResult  output  WIDTH+1  value being broadcast.
- cdbIsBranch  output  1  entry came from the branch unit.
- cdbTarget  output  WIDTH+1  resolved PC; 0 for ALU entries.
- cdbMispredict  output  1  mispredict flag; 0 for ALU entries.

Behaviour:
- Reset (globalReset=0, asynchronous): all cdb* outputs 0, FIFOs empty, RR pointer = ALU. aluReady and brReady read 1 once reset is released.
- Transfer: a transfer occurs when xValid && xReady at posedge; the entry is written to that source's FIFO.
- Ready: xReady = (count_x < DEPTH), derived from registered state only, with no dependence on same-cycle pops.
- Full FIFO: a push is refused while full even if a pop happens in the same cycle. Upstream must hold its data while ready=0.
- Pointers: DEPTH-sized storage with log2(DEPTH)+1-bit read/write pointers. Full is detected when the MSBs differ and the low bits are equal; empty when the pointers are equal. Wrap-around is natural modulo 2·DEPTH.
- Arbitration (each cycle the output register loads):
  - Only one FIFO non-empty: pop that FIFO.
  - Both non-empty: pop the source named by the RR pointer, then toggle the pointer.
  - Pointer changes only on a contended grant.
  - Both empty: cdbValid <= 0; other cdb* fields hold their previous values (don't-care).
- Output register: the popped entry loads into the cdb* registers with cdbValid=1. The CDB is never back-pressured, so each broadcast lasts exactly one cycle.
- Latency: input accepted at edge N appears on the CDB after edge N+1, when uncontended.
- ALU entries: cdbIsBranch=0, cdbTarget=0, cdbMispredict=0.
- Clear (synchronous, highest priority): at the edge where clear=1, both FIFOs empty and cdbValid <= 0. Inputs presented that cycle are dropped, and the RR pointer resets to ALU.
- Simultaneous push and pop on the same FIFO: both occur and the count is unchanged.
- Reset mid-operation: asserting reset asynchronously drops all entries and outputs immediately, with no completion of in-flight broadcasts.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- When defined: if a source's FIFO is empty and that source is granted, its same-cycle input loads directly into the output register and is not pushed. Latency is then 1 cycle.
  - Grant counts the bypass candidate as a requester.
  - Clear still suppresses the bypass.
- When undefined: all results pass through the FIFO, giving a 2-cycle minimum latency and no combinational input-to-register path across the arbiter.

Decomposition:
- Package cdb_pkg holds:
  - typedef struct cdb_entry_t {rob, result, isBranch, target, mispredict};
  - enum cdb_src_t {SRC_ALU, SRC_BRANCH};
  - default width constants.
- Sub-module cdb_fifo (parameterised on DEPTH, entry type, clear input), instantiated twice: once per source.
- Arbiter and output register live in cdb_arbiter.

Test Plan:
- Single ALU result: aluValid=1, aluRob=3, aluResult=0x10 for one cycle -> two edges later cdbValid=1, cdbRob=3, cdbResult=0x10, cdbIsBranch=0, for exactly one cycle.
- Collision: ALU (rob 1) and branch (rob 2) pushed same cycle after reset -> broadcast rob 1, then rob 2. A second collision (rob 4 ALU, rob 5 branch) -> branch rob 5 first, then rob 4.
- Back-pressure (DEPTH=2): both sources push every cycle -> each FIFO fills. aluReady/brReady go 0 and stay low while full; no entry is lost or duplicated, and the CDB emits the tags in strictly alternating ALU/branch order.
- Branch passthrough: brRob=6, brResult=0x24, brTarget=0x40, brMispredict=1 -> CDB shows cdbIsBranch=1, cdbTarget=0x40, cdbMispredict=1.
- Clear: three entries buffered, clear=1 together with a new aluValid -> next cycle cdbValid=0 and both readys=1, and no later broadcast of any of the four entries.
- Reset mid-stream: drive globalReset=0 between edges while cdbValid=1 -> cdbValid=0 immediately. After release, the first ALU result broadcasts with 2-cycle latency, or 1-cycle latency with CDB_BYPASS_EN.
